// File: rtl/weight_dump_pkg.sv
// rtl/weight_dump_pkg.sv - shared types and constants for the weight dump transmitter
package weight_dump_pkg;

  localparam int WORD_W = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_CSUM,
    S_FIN
  } state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/weight_dump_tx_uart.sv
// rtl/weight_dump_tx_uart.sv - 8N1 byte serializer; ready marks the last stop-bit cycle
module uart_tx_byte #(
  parameter int DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       txd,
  output logic       ready
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;

  assign ready = active && (bit_idx == 4'd9) && (cnt == CNT_MAX);

  // load wins over the running byte so a load on the ready cycle chains with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
      txd     <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= {1'b1, byte_in};
      txd     <= 1'b0;
    end else if (active) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          txd    <= 1'b1;
        end else begin
          txd     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_dump_tx.sv
// rtl/weight_dump_tx.sv - reads a RAM word range and streams it MSB-first over UART with an XOR checksum
module weight_dump_tx
  import weight_dump_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] index;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] sext;
  logic [7:0]        csum;
  logic [1:0]        byte_sel;
  logic              load;
  logic              ready;
  logic [7:0]        byte_in;
  logic              last_byte;
  logic              last_word;

  assign sext      = {{(WORD_W - DATA_W){ram_data[DATA_W-1]}}, ram_data};
  assign last_byte = (byte_sel == 2'd2);
  assign last_word = ((index + ADDR_W'(1)) == count_q);

  // The serializer is fed combinationally so the next byte starts on the ready edge
  always_comb begin
    load    = 1'b0;
    byte_in = 8'h00;
    case (state)
      S_IDLE: begin
        if (start && (word_count == '0)) begin
          load    = 1'b1;
          byte_in = 8'h00;
        end
      end
      S_LATCH: begin
        load    = 1'b1;
        byte_in = sext[23:16];
      end
      S_SEND: begin
        if (ready) begin
          if (!last_byte) begin
            load    = 1'b1;
            byte_in = (byte_sel == 2'd0) ? word_q[15:8] : word_q[7:0];
          end else if (last_word) begin
            load    = 1'b1;
            byte_in = csum;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      base_q   <= '0;
      count_q  <= '0;
      index    <= '0;
      word_q   <= '0;
      csum     <= 8'h00;
      byte_sel <= 2'd0;
    end else begin
      done   <= 1'b0;
      ram_re <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            index   <= '0;
            csum    <= 8'h00;
            busy    <= 1'b1;
            if (word_count == '0) begin
              state <= S_CSUM;
            end else begin
              state    <= S_READ;
              ram_re   <= 1'b1;
              ram_addr <= base_addr;
            end
          end
        end
        S_READ: state <= S_LATCH;
        S_LATCH: begin
          word_q   <= sext;
          csum     <= csum ^ sext[23:16] ^ sext[15:8] ^ sext[7:0];
          byte_sel <= 2'd0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (ready) begin
            if (!last_byte) begin
              byte_sel <= byte_sel + 2'd1;
            end else begin
              index <= index + ADDR_W'(1);
              if (last_word) begin
                state <= S_CSUM;
              end else begin
                state    <= S_READ;
                ram_re   <= 1'b1;
                ram_addr <= base_q + index + ADDR_W'(1);
              end
            end
          end
        end
        S_CSUM: begin
          if (ready) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .byte_in(byte_in),
    .txd    (txd),
    .ready  (ready)
  );

endmodule

// File: tb/tb_weight_dump_tx.sv
// tb/tb_weight_dump_tx.sv - scoreboard bench: UART decoder and RAM-read monitor against a byte-level model
module tb_weight_dump_tx;

  localparam int DIV = 25_000_000 / 115200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [23:0] word_count = '0;
  logic        ram_re;
  logic [23:0] ram_addr;
  logic [20:0] ram_data = '0;
  logic        txd;
  logic        busy;
  logic        done;

  always #20 clk = ~clk;

  weight_dump_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .txd       (txd),
    .busy      (busy),
    .done      (done)
  );

  logic [20:0] mem [logic [23:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  int          start_cyc_q[$];
  int          done_cnt = 0;
  int          byte_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 21'h0;
  endfunction

  always @(posedge clk) if (ram_re) ram_data <= rd(ram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // RAM read monitor
  logic prev_re = 1'b0;
  always @(negedge clk) begin
    if (ram_re && !rst) begin
      chk("ram_re_width", {31'd0, prev_re}, 0);
      if (exp_addr_q.size() == 0) chk("ram_re_unexpected", {31'd0, ram_re}, 0);
      else chk("ram_addr", {8'd0, ram_addr}, {8'd0, exp_addr_q.pop_front()});
    end
    prev_re = ram_re;
  end

  // done monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("busy_at_done", {31'd0, busy}, 0);
      chk("done_width", {31'd0, prev_done}, 0);
    end
    prev_done = done;
  end

  // UART decoder: every bit sampled at its first, middle and last cycle
  bit   rx_on = 1'b0;
  int   rx_cnt = 0;
  logic fb [10];
  logic mb [10];
  logic lb [10];
  always @(negedge clk) begin
    int k, off;
    logic [7:0] d;
    logic ok;
    if (rst) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on && txd === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
        start_cyc_q.push_back(cyc);
      end
      if (rx_on) begin
        k   = rx_cnt / DIV;
        off = rx_cnt % DIV;
        if (off == 0) fb[k] = txd;
        if (off == DIV / 2) mb[k] = txd;
        if (off == DIV - 1) lb[k] = txd;
        if (rx_cnt == 10 * DIV - 1) begin
          rx_on = 1'b0;
          ok = (mb[0] === 1'b0) && (mb[9] === 1'b1);
          for (int i = 0; i < 10; i++) ok = ok && (fb[i] === mb[i]) && (lb[i] === mb[i]);
          for (int i = 0; i < 8; i++) d[i] = mb[i+1];
          byte_cnt++;
          chk("uart_frame", {31'd0, ok}, 1);
          if (exp_q.size() == 0) chk("rx_extra_byte", exp_q.size(), 1);
          else chk("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  // Reference: sign-extend each word to 24 bits, emit MSB-first, XOR all bytes
  task automatic model(input logic [23:0] base, input int n);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic [23:0] a;
      logic signed [20:0] sw;
      int v;
      logic [7:0] b [3];
      a  = base + 24'(i);
      sw = rd(a);
      v  = int'(sw);
      b[0] = 8'((v >> 16) & 255);
      b[1] = 8'((v >> 8) & 255);
      b[2] = 8'(v & 255);
      for (int j = 0; j < 3; j++) begin
        exp_q.push_back(b[j]);
        cs = cs ^ b[j];
      end
      exp_addr_q.push_back(a);
    end
    exp_q.push_back(cs);
  endtask

  task automatic run_dump(input logic [23:0] base, input int n, input bit spam);
    int c, t, d0, lim, total, expd;
    bit seen;
    model(base, n);
    start_cyc_q.delete();
    d0    = done_cnt;
    total = 1 + n * (2 + 30 * DIV) + 10 * DIV + 1;
    lim   = total + 20;
    @(negedge clk);
    base_addr  = base;
    word_count = 24'(n);
    start      = 1'b1;
    c          = cyc;
    @(negedge clk);
    chk("busy_rise", {31'd0, busy}, 1);
    start = spam ? ($urandom_range(0, 3) == 0) : 1'b0;
    seen  = 1'b0;
    for (t = 0; t < lim; t++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      if (spam) start = ($urandom_range(0, 3) == 0);
    end
    chk("done_seen", {31'd0, seen}, 1);
    if (seen) begin
      chk("duration", cyc - c, total - 1);
      start = spam;
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("addr_left", exp_addr_q.size(), 0);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("byte_starts", start_cyc_q.size(), 3 * n + 1);
    if (start_cyc_q.size() == 3 * n + 1) begin
      chk("first_start_bit", start_cyc_q[0] - c, (n == 0) ? 1 : 3);
      for (int j = 1; j <= 3 * n; j++) begin
        expd = 10 * DIV + ((j < 3 * n && j % 3 == 0) ? 2 : 0);
        chk("byte_spacing", start_cyc_q[j] - start_cyc_q[j-1], expd);
      end
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    #(40 * 99000);
    $display("FAIL watchdog: cycle %0d required below 99000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] b;
    int b0, t;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ram_re", {31'd0, ram_re}, 0);
    chk("rst_ram_addr", {8'd0, ram_addr}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mem[24'h000010] = 21'h0ABCDE;
    run_dump(24'h000010, 1, 1'b0);

    mem[24'h000005] = 21'h1FFFFF;
    run_dump(24'h000005, 1, 1'b0);

    run_dump(24'($urandom), 0, 1'b0);

    mem[24'hFFFFFF] = 21'($urandom);
    mem[24'h000000] = 21'($urandom);
    run_dump(24'hFFFFFF, 2, 1'b0);

    b = 24'($urandom);
    for (int i = 0; i < 3; i++) mem[b + 24'(i)] = 21'($urandom);
    run_dump(b, 3, 1'b1);

    // abort in the middle of the second word
    b = 24'($urandom);
    for (int i = 0; i < 3; i++) mem[b + 24'(i)] = 21'($urandom);
    model(b, 3);
    b0 = byte_cnt;
    t  = done_cnt;
    @(negedge clk);
    base_addr  = b;
    word_count = 24'd3;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4 * 10 * DIV && byte_cnt < b0 + 3; i++) @(negedge clk);
    chk("abort_reached_word2", byte_cnt - b0, 3);
    repeat (15 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_txd", {31'd0, txd}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (12 * DIV) @(negedge clk);
    chk("abort_no_done", done_cnt - t, 0);
    chk("abort_bytes", byte_cnt - b0, 4);

    b = 24'($urandom);
    mem[b] = 21'($urandom);
    run_dump(b, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
